adder_bist_driver: RTL and testbench

//  On-chip stimulus/check engine for the 8-bit adder core: drives operand pairs into the adder,

---
 rtl/adder_bist_if.sv | 12 +
 rtl/adder_bist_driver.sv | 136 +++++++++++++
 tb/tb_adder_bist_driver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_if.sv
// Operand/result link between the BIST driver and the 8-bit adder core.
// Handshake: none. Operands are static from APPLY through CHECK; the result is sampled in CHECK.
interface adder_bist_if;
  logic [7:0] dut_a;
  logic [7:0] dut_b;
  logic       dut_cin;
  logic [7:0] dut_sum;
  logic       dut_cout;

  modport master (output dut_a, output dut_b, output dut_cin, input dut_sum, input dut_cout);
  modport slave  (input dut_a, input dut_b, input dut_cin, output dut_sum, output dut_cout);
endinterface

// File: rtl/adder_bist_driver.sv
// Self-test engine for the 8-bit adder: drives fixed corner vectors then LFSR vectors,
// checks {cout,sum} against a golden add and accumulates error count / first failing index.
module adder_bist_driver #(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  adder_bist_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         first_fail,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q;
  logic [3:0]  wait_cnt_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  a_q, b_q;
  logic        cin_q;
  logic [15:0] err_q, ff_q;
  logic        pass_q;

  logic [8:0]  exp_sum;
  logic        mismatch;
  logic [15:0] err_d, ff_d, idx_nxt;
  logic [7:0]  lfsr_d;
  logic [16:0] vec_nxt;
  logic        launch;

  // Vector i as {a, b, cin}; indices 0..3 are carry/overflow corner cases.
  function automatic logic [16:0] vec_of(input logic [15:0] i, input logic [7:0] l);
    logic [7:0] a, b;
    case (i)
      16'd0:   begin a = 8'h00; b = 8'h00; end
      16'd1:   begin a = 8'hFF; b = 8'h01; end
      16'd2:   begin a = 8'hFF; b = 8'hFF; end
      16'd3:   begin a = 8'h80; b = 8'h80; end
      default: begin a = l;     b = {l[3:0], l[7:4]}; end
    endcase
    return {a, b, i[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = (SETTLE_CYCLES == 0) ? CHECK : WAIT;
      WAIT:    if (wait_cnt_q == SETTLE_LAST) state_d = CHECK;
      CHECK:   state_d = (idx_q == LAST_IDX) ? DONE : APPLY;
      DONE:    if (start) state_d = APPLY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    exp_sum  = {1'b0, a_q} + {1'b0, b_q} + {8'b0, cin_q};
    mismatch = ({bus.dut_cout, bus.dut_sum} != exp_sum);
    err_d    = (mismatch && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
    ff_d     = (mismatch && (ff_q == 16'hFFFF)) ? idx_q : ff_q;
    // The LFSR only advances once random vectors are in use, so vector 4 sees the seed.
    lfsr_d   = (idx_q >= 16'd4) ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                                : lfsr_q;
    idx_nxt  = idx_q + 16'd1;
    vec_nxt  = vec_of(idx_nxt, lfsr_d);
    launch   = ((state_q == IDLE) || (state_q == DONE)) && (state_d == APPLY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 16'd0;
      wait_cnt_q <= 4'd0;
      lfsr_q     <= SEED_EFF;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      cin_q      <= 1'b0;
      err_q      <= 16'd0;
      ff_q       <= 16'hFFFF;
      pass_q     <= 1'b0;
    end else begin
      if (launch) begin
        idx_q               <= 16'd0;
        err_q               <= 16'd0;
        ff_q                <= 16'hFFFF;
        lfsr_q              <= SEED_EFF;
        pass_q              <= 1'b0;
        {a_q, b_q, cin_q}   <= vec_of(16'd0, SEED_EFF);
      end
      if (state_q == APPLY) wait_cnt_q <= 4'd0;
      if (state_q == WAIT)  wait_cnt_q <= wait_cnt_q + 4'd1;
      if (state_q == CHECK) begin
        err_q  <= err_d;
        ff_q   <= ff_d;
        lfsr_q <= lfsr_d;
        if (state_d == APPLY) begin
          idx_q             <= idx_nxt;
          {a_q, b_q, cin_q} <= vec_nxt;
        end
        if (state_d == DONE) pass_q <= (err_d == 16'd0);
      end
    end
  end

  assign bus.dut_a   = a_q;
  assign bus.dut_b   = b_q;
  assign bus.dut_cin = cin_q;
  assign busy        = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_fail  = ff_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: behavioural adder with injectable faults, expected run results
// and driven vectors queued by the driver, popped and compared by negedge monitors.
module tb_adder_bist_driver;

  logic clk = 1'b0;
  logic rst, start, start2;
  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int fault_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_bist_if bus1();
  adder_bist_if bus2();

  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err1, ff1, err2, ff2;
  logic [2:0]  st1, st2;

  adder_bist_driver #(.NUM_VECTORS(8), .SETTLE_CYCLES(1), .SEED(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail(ff1), .state_dbg(st1));

  adder_bist_driver #(.NUM_VECTORS(8), .SETTLE_CYCLES(0), .SEED(8'h00)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail(ff2), .state_dbg(st2));

  // Adder model: 0 ideal, 1 sum[0] stuck-at-0, 2 cout tied 0.
  always_comb begin
    logic [8:0] r;
    r = {1'b0, bus1.dut_a} + {1'b0, bus1.dut_b} + {8'b0, bus1.dut_cin};
    if (fault_mode == 1) r[0] = 1'b0;
    if (fault_mode == 2) r[8] = 1'b0;
    {bus1.dut_cout, bus1.dut_sum} = r;
  end

  always_comb begin
    {bus2.dut_cout, bus2.dut_sum} = {1'b0, bus2.dut_a} + {1'b0, bus2.dut_b} + {8'b0, bus2.dut_cin};
  end

  // Expected run result: {pass, err_count, first_fail, done cycle}; vectors: {a, b, cin}.
  logic [64:0] exp_q[$];
  logic [64:0] exp2_q[$];
  logic [16:0] vec_q[$];
  logic [16:0] vec2_q[$];
  logic [16:0] vec_tab1[8];
  logic [16:0] vec_tab2[8];

  initial begin
    vec_tab1 = '{{8'h00, 8'h00, 1'b0}, {8'hFF, 8'h01, 1'b1}, {8'hFF, 8'hFF, 1'b0}, {8'h80, 8'h80, 1'b1},
                 {8'hA5, 8'h5A, 1'b0}, {8'h4A, 8'hA4, 1'b1}, {8'h95, 8'h59, 1'b0}, {8'h2A, 8'hA2, 1'b1}};
    vec_tab2 = '{{8'h00, 8'h00, 1'b0}, {8'hFF, 8'h01, 1'b1}, {8'hFF, 8'hFF, 1'b0}, {8'h80, 8'h80, 1'b1},
                 {8'h01, 8'h10, 1'b0}, {8'h02, 8'h20, 1'b1}, {8'h04, 8'h40, 1'b0}, {8'h08, 8'h80, 1'b1}};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic done1_prev = 1'b0;
  logic done2_prev = 1'b0;

  always @(negedge clk) begin
    logic [64:0] e;
    logic [16:0] v;
    if (rst) begin
      done1_prev = 1'b0;
    end else begin
      if (done1 && !done1_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dut1_unexpected_done at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("dut1_pass", 64'(pass1), 64'(e[64]));
          check("dut1_err_count", 64'(err1), 64'(e[63:48]));
          check("dut1_first_fail", 64'(ff1), 64'(e[47:32]));
          check("dut1_done_cycle", 64'(cyc), 64'(e[31:0]));
        end
      end
      done1_prev = done1;
      if (st1 == 3'd1 && vec_q.size() > 0) begin
        v = vec_q.pop_front();
        check("dut1_vector", 64'({bus1.dut_a, bus1.dut_b, bus1.dut_cin}), 64'(v));
      end
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    logic [16:0] v;
    if (rst) begin
      done2_prev = 1'b0;
    end else begin
      if (done2 && !done2_prev && exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        check("dut2_pass", 64'(pass2), 64'(e[64]));
        check("dut2_err_count", 64'(err2), 64'(e[63:48]));
        check("dut2_done_cycle", 64'(cyc), 64'(e[31:0]));
      end
      done2_prev = done2;
      if (st2 == 3'd1 && vec2_q.size() > 0) begin
        v = vec2_q.pop_front();
        check("dut2_vector", 64'({bus2.dut_a, bus2.dut_b, bus2.dut_cin}), 64'(v));
      end
    end
  end

  task automatic push_vecs1();
    for (int i = 0; i < 8; i++) vec_q.push_back(vec_tab1[i]);
  endtask

  task automatic pulse1(output int unsigned v);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; v = cyc; start = 1'b0;
  endtask

  task automatic expect1(input logic p, input logic [15:0] e, input logic [15:0] f, input int unsigned c);
    exp_q.push_back({p, e, f, c});
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() > 0 || exp2_q.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0 || exp2_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding", exp_q.size(), exp2_q.size());
      exp_q.delete(); exp2_q.delete();
    end
  endtask

  initial begin
    int unsigned v;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy1), 64'd0);
    check("reset_done", 64'(done1), 64'd0);
    check("reset_pass", 64'(pass1), 64'd0);
    check("reset_err", 64'(err1), 64'd0);
    check("reset_first_fail", 64'(ff1), 64'hFFFF);
    check("reset_operands", 64'({bus1.dut_a, bus1.dut_b, bus1.dut_cin}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Ideal adder: full pass, done 24 edges after the start-sampling edge.
    fault_mode = 0;
    push_vecs1(); pulse1(v); expect1(1'b1, 16'd0, 16'hFFFF, v + 24);
    drain();

    // sum[0] stuck-at-0: vectors 1,3,4,5,7 have odd sums.
    fault_mode = 1;
    push_vecs1(); pulse1(v); expect1(1'b0, 16'd5, 16'd1, v + 24);
    drain();

    // cout tied 0: vectors 1,2,3 carry out.
    fault_mode = 2;
    push_vecs1(); pulse1(v); expect1(1'b0, 16'd3, 16'd1, v + 24);
    drain();

    // Restart from DONE with prior errors clears results and re-drives vector 0.
    fault_mode = 0;
    push_vecs1(); pulse1(v);
    check("restart_err_cleared", 64'(err1), 64'd0);
    check("restart_ff_cleared", 64'(ff1), 64'hFFFF);
    check("restart_vec0", 64'({bus1.dut_a, bus1.dut_b, bus1.dut_cin}), 64'd0);
    expect1(1'b1, 16'd0, 16'hFFFF, v + 24);
    // start pulses while busy must not disturb timing.
    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(posedge clk);
    end
    drain();

    // Reset during WAIT of vector 3.
    push_vecs1(); pulse1(v);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("wait_state_before_reset", 64'(st1), 64'd2);
    check("vec3_a_before_reset", 64'(bus1.dut_a), 64'h80);
    rst = 1'b1;
    @(posedge clk); #1;
    vec_q.delete();
    check("midrun_reset_busy", 64'(busy1), 64'd0);
    check("midrun_reset_state", 64'(st1), 64'd0);
    check("midrun_reset_operands", 64'({bus1.dut_a, bus1.dut_b, bus1.dut_cin}), 64'd0);
    check("midrun_reset_ff", 64'(ff1), 64'hFFFF);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("idle_after_reset", 64'(done1), 64'd0);
    push_vecs1(); pulse1(v); expect1(1'b1, 16'd0, 16'hFFFF, v + 24);
    drain();

    // start held high: back-to-back runs with one cycle in DONE.
    push_vecs1(); push_vecs1();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; v = cyc;
    expect1(1'b1, 16'd0, 16'hFFFF, v + 24);
    expect1(1'b1, 16'd0, 16'hFFFF, v + 49);
    repeat (25) @(posedge clk);
    #1; start = 1'b0;
    drain();

    // SEED=00 -> 01, no settle: 2 cycles per vector.
    for (int i = 0; i < 8; i++) vec2_q.push_back(vec_tab2[i]);
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; v = cyc; start2 = 1'b0;
    exp2_q.push_back({1'b1, 16'd0, 16'hFFFF, v + 16});
    drain();
    check("dut2_vectors_consumed", 64'(vec2_q.size()), 64'd0);
    check("dut1_vectors_consumed", 64'(vec_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
